// File: rtl/dmem_sram_bridge_pkg.sv
// Shared types and helpers for the data-memory strobe to 16-bit async SRAM bridge.
// The RAISIN64_DMEM_ALIGN_CHECK_EN build uses is_misaligned to reject unaligned accesses.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        DW_64 = 2'd0,
        DW_32 = 2'd1,
        DW_16 = 2'd2,
        DW_8  = 2'd3
    } dmem_width_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_DONE = 2'd2
    } bridge_state_e;

    function automatic logic [2:0] beats_for_width(input dmem_width_e width);
        logic [2:0] beats;
        beats = 3'd1;
        case (width)
            DW_64:   beats = 3'd4;
            DW_32:   beats = 3'd2;
            default: beats = 3'd1;
        endcase
        return beats;
    endfunction

    // Only the low three byte-address bits can make an access misaligned.
    function automatic logic is_misaligned(input logic [2:0] addr, input dmem_width_e width);
        logic mis;
        mis = 1'b0;
        case (width)
            DW_64:   mis = (addr != 3'b000);
            DW_32:   mis = (addr[1:0] != 2'b00);
            DW_16:   mis = addr[0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_sram_bridge_if.sv
// Pipeline data-memory strobe protocol; the pipeline is master, the memory side is slave.
interface dmem_sram_bridge_if;

    logic [63:0] dmem_addr;
    logic [63:0] dmem_dout;
    logic [1:0]  dmem_write_width;
    logic        dmem_rstrobe;
    logic        dmem_wstrobe;
    logic [63:0] dmem_din;
    logic        dmem_cycle_complete;
    logic        dmem_err;

    modport master (
        output dmem_addr,
        output dmem_dout,
        output dmem_write_width,
        output dmem_rstrobe,
        output dmem_wstrobe,
        input  dmem_din,
        input  dmem_cycle_complete,
        input  dmem_err
    );

    modport slave (
        input  dmem_addr,
        input  dmem_dout,
        input  dmem_write_width,
        input  dmem_rstrobe,
        input  dmem_wstrobe,
        output dmem_din,
        output dmem_cycle_complete,
        output dmem_err
    );

endinterface

// File: rtl/dmem_sram_bridge.sv
// Serves 8/16/32/64-bit dmem strobe accesses from a 16-bit async SRAM as halfword beats.
// Define RAISIN64_DMEM_ALIGN_CHECK_EN to reject misaligned accesses with dmem_err.
//
// state   | meaning
// IDLE    | waiting for dmem_rstrobe / dmem_wstrobe
// BEAT    | driving one SRAM halfword beat for WAIT_STATES+1 cycles
// DONE    | one-cycle dmem_cycle_complete pulse
module dmem_sram_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    dmem_sram_bridge_if.slave dmem,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_wdata,
    input  logic [15:0]       sram_rdata,
    output logic              sram_ce,
    output logic              sram_oe,
    output logic              sram_we,
    output logic [1:0]        sram_be
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    localparam logic       NO_WAIT   = (WAIT_STATES == 0);

    bridge_state_e     state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [3:0]        wait_q, wait_d;
    logic [ADDR_W-1:0] base_q, base_d;
    dmem_width_e       width_q, width_d;
    logic [63:0]       wdata_q, wdata_d;
    logic              lane_q, lane_d;
    logic              write_q, write_d;
    logic [63:0]       din_q, din_d;

    logic              accept;
    logic              misalign;
    dmem_width_e       width_in;
    logic [ADDR_W-1:0] hw_addr_in;
    logic [ADDR_W-1:0] base_in;
    logic              last_wait;
    logic              last_beat;
    logic [2:0]        beats;
    logic              in_beat;

    logic unused_addr_hi;
    assign unused_addr_hi = ^dmem.dmem_addr[63:ADDR_W+1];

    assign width_in   = dmem_width_e'(dmem.dmem_write_width);
    assign hw_addr_in = dmem.dmem_addr[ADDR_W:1];
    assign accept     = (state_q == ST_IDLE) && (dmem.dmem_rstrobe || dmem.dmem_wstrobe);

`ifdef RAISIN64_DMEM_ALIGN_CHECK_EN
    assign misalign = is_misaligned(dmem.dmem_addr[2:0], width_in);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        base_in = hw_addr_in;
        case (width_in)
            DW_64:   base_in = {hw_addr_in[ADDR_W-1:2], 2'b00};
            DW_32:   base_in = {hw_addr_in[ADDR_W-1:1], 1'b0};
            default: base_in = hw_addr_in;
        endcase
    end

    assign beats     = beats_for_width(width_q);
    assign last_wait = (wait_q == 4'd0);
    assign last_beat = ({1'b0, beat_q} == (beats - 3'd1));
    assign in_beat   = (state_q == ST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= 2'd0;
            wait_q  <= 4'd0;
            base_q  <= '0;
            width_q <= DW_64;
            wdata_q <= 64'd0;
            lane_q  <= 1'b0;
            write_q <= 1'b0;
            din_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            base_q  <= base_d;
            width_q <= width_d;
            wdata_q <= wdata_d;
            lane_q  <= lane_d;
            write_q <= write_d;
            din_q   <= din_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        base_d  = base_q;
        width_d = width_q;
        wdata_d = wdata_q;
        lane_d  = lane_q;
        write_d = write_q;
        din_d   = din_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // A store wins when both strobes arrive together.
                    base_d  = base_in;
                    width_d = width_in;
                    wdata_d = dmem.dmem_dout;
                    lane_d  = dmem.dmem_addr[0];
                    write_d = dmem.dmem_wstrobe;
                    beat_d  = 2'd0;
                    wait_d  = WAIT_INIT;
                    if (misalign) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BEAT;
                        if (!dmem.dmem_wstrobe) begin
                            din_d = 64'd0;
                        end
                    end
                end
            end
            ST_BEAT: begin
                if (last_wait) begin
                    if (!write_q) begin
                        if (width_q == DW_8) begin
                            din_d = {56'd0, (lane_q ? sram_rdata[15:8] : sram_rdata[7:0])};
                        end else begin
                            din_d[{beat_q, 4'b0000} +: 16] = sram_rdata;
                        end
                    end
                    if (last_beat) begin
                        state_d = ST_DONE;
                        wait_d  = 4'd0;
                        beat_d  = 2'd0;
                    end else begin
                        beat_d = beat_q + 2'd1;
                        wait_d = WAIT_INIT;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        sram_addr  = '0;
        sram_wdata = 16'd0;
        sram_ce    = 1'b0;
        sram_oe    = 1'b0;
        sram_we    = 1'b0;
        sram_be    = 2'b00;
        if (in_beat) begin
            sram_addr = base_q + ADDR_W'(beat_q);
            sram_ce   = 1'b1;
            sram_oe   = !write_q;
            // The last cycle of a beat releases WE so data holds past the write edge.
            sram_we   = write_q && (!last_wait || NO_WAIT);
            if (width_q == DW_8) begin
                sram_be = lane_q ? 2'b10 : 2'b01;
            end else begin
                sram_be = 2'b11;
            end
            if (write_q) begin
                if (width_q == DW_8) begin
                    sram_wdata = {wdata_q[7:0], wdata_q[7:0]};
                end else begin
                    sram_wdata = wdata_q[{beat_q, 4'b0000} +: 16];
                end
            end
        end
    end

    assign dmem.dmem_din            = din_q;
    assign dmem.dmem_cycle_complete = (state_q == ST_DONE);

`ifdef RAISIN64_DMEM_ALIGN_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= misalign;
        end
    end

    assign dmem.dmem_err = err_q && (state_q == ST_DONE);
`else
    assign dmem.dmem_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed bench: two bridges (W=0 and W=1) share one SRAM model; expected values are hand-computed.
module tb_dmem_sram_bridge;
    import dmem_bridge_pkg::*;

    localparam int AW  = 18;
    localparam int WIN = 14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_sram_bridge_if b0();
    dmem_sram_bridge_if b1();

    logic [AW-1:0] s0_addr, s1_addr;
    logic [15:0]   s0_wdata, s1_wdata, s0_rdata, s1_rdata;
    logic          s0_ce, s0_oe, s0_we, s1_ce, s1_oe, s1_we;
    logic [1:0]    s0_be, s1_be;

    dmem_sram_bridge #(.ADDR_W(AW), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .dmem(b0),
        .sram_addr(s0_addr), .sram_wdata(s0_wdata), .sram_rdata(s0_rdata),
        .sram_ce(s0_ce), .sram_oe(s0_oe), .sram_we(s0_we), .sram_be(s0_be)
    );

    dmem_sram_bridge #(.ADDR_W(AW), .WAIT_STATES(1)) u_dut1 (
        .clk(clk), .rst(rst), .dmem(b1),
        .sram_addr(s1_addr), .sram_wdata(s1_wdata), .sram_rdata(s1_rdata),
        .sram_ce(s1_ce), .sram_oe(s1_oe), .sram_we(s1_we), .sram_be(s1_be)
    );

    logic [15:0] mem [0:255];
    logic        mem_load;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
        end else begin
            if (s0_ce && s0_we) begin
                if (s0_be[0]) mem[s0_addr[7:0]][7:0]  <= s0_wdata[7:0];
                if (s0_be[1]) mem[s0_addr[7:0]][15:8] <= s0_wdata[15:8];
            end
            if (s1_ce && s1_we) begin
                if (s1_be[0]) mem[s1_addr[7:0]][7:0]  <= s1_wdata[7:0];
                if (s1_be[1]) mem[s1_addr[7:0]][15:8] <= s1_wdata[15:8];
            end
        end
    end

    assign s0_rdata = (s0_ce && s0_oe) ? mem[s0_addr[7:0]] : 16'h0000;
    assign s1_rdata = (s1_ce && s1_oe) ? mem[s1_addr[7:0]] : 16'h0000;

    int            sel;
    logic [AW-1:0] sel_addr;
    logic [15:0]   sel_wdata;
    logic          sel_ce, sel_oe, sel_we, sel_cc, sel_err;
    logic [1:0]    sel_be;
    logic [63:0]   sel_din;

    always_comb begin
        if (sel == 0) begin
            sel_addr = s0_addr; sel_wdata = s0_wdata; sel_ce = s0_ce; sel_oe = s0_oe;
            sel_we = s0_we; sel_be = s0_be; sel_din = b0.dmem_din;
            sel_cc = b0.dmem_cycle_complete; sel_err = b0.dmem_err;
        end else begin
            sel_addr = s1_addr; sel_wdata = s1_wdata; sel_ce = s1_ce; sel_oe = s1_oe;
            sel_we = s1_we; sel_be = s1_be; sel_din = b1.dmem_din;
            sel_cc = b1.dmem_cycle_complete; sel_err = b1.dmem_err;
        end
    end

    logic [AW-1:0] obs_addr  [0:15];
    logic [15:0]   obs_wdata [0:15];
    logic          obs_ce    [0:15];
    logic          obs_oe    [0:15];
    logic          obs_we    [0:15];
    logic          obs_cc    [0:15];
    logic          obs_err   [0:15];
    logic [1:0]    obs_be    [0:15];
    logic [63:0]   obs_din   [0:15];
    int            done_cyc;
    int            n_done;
    int            checks = 0;
    int            errors = 0;

    task automatic drive(input int dut, input logic rd, input logic wr, input logic [1:0] w,
                         input logic [63:0] a, input logic [63:0] d);
        if (dut == 0) begin
            b0.dmem_rstrobe = rd; b0.dmem_wstrobe = wr; b0.dmem_write_width = w;
            b0.dmem_addr = a; b0.dmem_dout = d;
        end else begin
            b1.dmem_rstrobe = rd; b1.dmem_wstrobe = wr; b1.dmem_write_width = w;
            b1.dmem_addr = a; b1.dmem_dout = d;
        end
    endtask

    // inj: 0 none, 1 reset pulse over cycles 3..4, 2 extra load strobe in cycle 1
    task automatic run_access(input int dut, input logic rd, input logic wr, input logic [1:0] w,
                              input logic [63:0] a, input logic [63:0] d, input int inj);
        sel = dut;
        @(negedge clk);
        drive(dut, rd, wr, w, a, d);
        @(negedge clk);
        drive(dut, 1'b0, 1'b0, w, a, d);
        done_cyc = -1;
        n_done   = 0;
        for (int c = 1; c <= WIN; c++) begin
            obs_addr[c] = sel_addr; obs_wdata[c] = sel_wdata; obs_ce[c] = sel_ce;
            obs_oe[c] = sel_oe; obs_we[c] = sel_we; obs_be[c] = sel_be;
            obs_din[c] = sel_din; obs_cc[c] = sel_cc; obs_err[c] = sel_err;
            if (sel_cc) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (inj == 1 && c == 3) rst = 1'b1;
            if (inj == 1 && c == 4) rst = 1'b0;
            if (inj == 2 && c == 1) drive(dut, 1'b1, 1'b0, DW_64, 64'h20, 64'h0);
            if (inj == 2 && c == 2) drive(dut, 1'b0, 1'b0, DW_64, 64'h20, 64'h0);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({s1_ce, s1_oe, s1_we, s1_be, s1_addr, s1_wdata} !== 39'd0) begin
            errors++; $display("FAIL reset_sram_outputs: got %h want 0", {s1_ce, s1_oe, s1_we, s1_be, s1_addr, s1_wdata});
        end
        checks++;
        if ({b1.dmem_din, b1.dmem_cycle_complete, b1.dmem_err} !== 66'd0) begin
            errors++; $display("FAIL reset_dmem_outputs: got %h want 0", {b1.dmem_din, b1.dmem_cycle_complete, b1.dmem_err});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({s0_ce, s1_ce, b0.dmem_cycle_complete, b1.dmem_cycle_complete} !== 4'd0) begin
            errors++; $display("FAIL idle_after_reset: got %b want 0000", {s0_ce, s1_ce, b0.dmem_cycle_complete, b1.dmem_cycle_complete});
        end
    endtask

    task automatic test_store64();
        logic [15:0] hw [0:3];
        hw[0] = 16'h7788; hw[1] = 16'h5566; hw[2] = 16'h3344; hw[3] = 16'h1122;
        run_access(1, 1'b0, 1'b1, DW_64, 64'h10, 64'h1122334455667788, 0);
        checks++;
        if (done_cyc !== 9 || n_done !== 1) begin
            errors++; $display("FAIL store64_complete: got cycle %0d count %0d want cycle 9 count 1", done_cyc, n_done);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({obs_ce[1+2*k], obs_we[1+2*k], obs_be[1+2*k], obs_addr[1+2*k], obs_wdata[1+2*k]} !==
                {1'b1, 1'b1, 2'b11, AW'(8 + k), hw[k]}) begin
                errors++; $display("FAIL store64_beat%0d_first: got addr %0d data %h we %b want addr %0d data %h we 1",
                                   k, obs_addr[1+2*k], obs_wdata[1+2*k], obs_we[1+2*k], 8 + k, hw[k]);
            end
            checks++;
            if ({obs_ce[2+2*k], obs_we[2+2*k], obs_addr[2+2*k], obs_wdata[2+2*k]} !==
                {1'b1, 1'b0, AW'(8 + k), hw[k]}) begin
                errors++; $display("FAIL store64_beat%0d_last: got addr %0d data %h we %b want addr %0d data %h we 0",
                                   k, obs_addr[2+2*k], obs_wdata[2+2*k], obs_we[2+2*k], 8 + k, hw[k]);
            end
            checks++;
            if (mem[8+k] !== hw[k]) begin
                errors++; $display("FAIL store64_mem%0d: got %h want %h", 8 + k, mem[8+k], hw[k]);
            end
        end
        checks++;
        if (obs_ce[9] !== 1'b0 || obs_cc[10] !== 1'b0) begin
            errors++; $display("FAIL store64_done_shape: got ce9 %b cc10 %b want 0 0", obs_ce[9], obs_cc[10]);
        end
    endtask

    task automatic test_load64();
        run_access(0, 1'b1, 1'b0, DW_64, 64'h10, 64'h0, 0);
        checks++;
        if (done_cyc !== 5 || n_done !== 1) begin
            errors++; $display("FAIL load64_complete: got cycle %0d count %0d want cycle 5 count 1", done_cyc, n_done);
        end
        checks++;
        if (obs_din[5] !== 64'h1122334455667788) begin
            errors++; $display("FAIL load64_data: got %h want 1122334455667788", obs_din[5]);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({obs_ce[1+k], obs_oe[1+k], obs_we[1+k], obs_addr[1+k]} !== {1'b1, 1'b1, 1'b0, AW'(8 + k)}) begin
                errors++; $display("FAIL load64_beat%0d: got addr %0d ce/oe/we %b%b%b want addr %0d 110",
                                   k, obs_addr[1+k], obs_ce[1+k], obs_oe[1+k], obs_we[1+k], 8 + k);
            end
        end
    endtask

    task automatic test_byte();
        run_access(1, 1'b0, 1'b1, DW_8, 64'h13, 64'hAB, 0);
        checks++;
        if ({obs_addr[1], obs_be[1], obs_wdata[1]} !== {AW'(9), 2'b10, 16'hABAB}) begin
            errors++; $display("FAIL byte_store_drive: got addr %0d be %b data %h want addr 9 be 10 data abab",
                               obs_addr[1], obs_be[1], obs_wdata[1]);
        end
        checks++;
        if (done_cyc !== 3 || mem[9] !== 16'hAB66) begin
            errors++; $display("FAIL byte_store_result: got cycle %0d mem %h want cycle 3 mem ab66", done_cyc, mem[9]);
        end
        run_access(0, 1'b1, 1'b0, DW_8, 64'h13, 64'h0, 0);
        checks++;
        if (done_cyc !== 2 || obs_din[2] !== 64'h00000000000000AB) begin
            errors++; $display("FAIL byte_load: got cycle %0d din %h want cycle 2 din ab", done_cyc, obs_din[2]);
        end
        checks++;
        if (obs_be[1] !== 2'b10) begin
            errors++; $display("FAIL byte_load_be: got %b want 10", obs_be[1]);
        end
    endtask

    task automatic test_misaligned();
        run_access(0, 1'b1, 1'b0, DW_32, 64'h6, 64'h0, 0);
`ifdef RAISIN64_DMEM_ALIGN_CHECK_EN
        checks++;
        if (done_cyc !== 1 || obs_err[1] !== 1'b1 || obs_ce[1] !== 1'b0) begin
            errors++; $display("FAIL misaligned_reject: got cycle %0d err %b ce %b want cycle 1 err 1 ce 0",
                               done_cyc, obs_err[1], obs_ce[1]);
        end
        checks++;
        if (obs_din[1] !== 64'hAB) begin
            errors++; $display("FAIL misaligned_din_hold: got %h want ab", obs_din[1]);
        end
`else
        checks++;
        if (obs_addr[1] !== AW'(2) || obs_addr[2] !== AW'(3) || done_cyc !== 3) begin
            errors++; $display("FAIL misaligned_truncate: got addrs %0d %0d cycle %0d want 2 3 cycle 3",
                               obs_addr[1], obs_addr[2], done_cyc);
        end
        checks++;
        if (obs_din[3] !== 64'h00000000A003A002 || obs_err[3] !== 1'b0) begin
            errors++; $display("FAIL misaligned_data: got din %h err %b want a003a002 err 0", obs_din[3], obs_err[3]);
        end
`endif
    endtask

    task automatic test_reset_mid();
        run_access(1, 1'b1, 1'b0, DW_64, 64'h10, 64'h0, 1);
        checks++;
        if (obs_ce[3] !== 1'b1) begin
            errors++; $display("FAIL reset_mid_active: got ce %b want 1", obs_ce[3]);
        end
        checks++;
        if ({obs_ce[4], obs_oe[4], obs_we[4], obs_be[4], obs_addr[4], obs_wdata[4], obs_cc[4], obs_din[4]} !== 104'd0) begin
            errors++; $display("FAIL reset_mid_outputs: got ce %b oe %b addr %0d din %h want all 0",
                               obs_ce[4], obs_oe[4], obs_addr[4], obs_din[4]);
        end
        checks++;
        if (n_done !== 0) begin
            errors++; $display("FAIL reset_mid_no_complete: got %0d want 0", n_done);
        end
        run_access(1, 1'b1, 1'b0, DW_16, 64'h12, 64'h0, 0);
        checks++;
        if (done_cyc !== 3 || n_done !== 1 || obs_din[3] !== 64'hAB66) begin
            errors++; $display("FAIL load16_after_reset: got cycle %0d count %0d din %h want cycle 3 count 1 din ab66",
                               done_cyc, n_done, obs_din[3]);
        end
    endtask

    task automatic test_back_to_back();
        int oe_seen;
        run_access(1, 1'b1, 1'b1, DW_16, 64'h4, 64'hBEEF, 2);
        oe_seen = 0;
        for (int c = 1; c <= WIN; c++) if (obs_oe[c]) oe_seen++;
        checks++;
        if (obs_we[1] !== 1'b1 || oe_seen !== 0) begin
            errors++; $display("FAIL both_strobes_store: got we %b oe cycles %0d want we 1 oe cycles 0", obs_we[1], oe_seen);
        end
        checks++;
        if (done_cyc !== 3 || n_done !== 1) begin
            errors++; $display("FAIL busy_strobe_ignored: got cycle %0d count %0d want cycle 3 count 1", done_cyc, n_done);
        end
        checks++;
        if (mem[2] !== 16'hBEEF || obs_din[WIN] !== 64'hAB66) begin
            errors++; $display("FAIL both_strobes_result: got mem %h din %h want beef ab66", mem[2], obs_din[WIN]);
        end
    endtask

    initial begin
        rst      = 1'b1;
        mem_load = 1'b1;
        sel      = 1;
        drive(0, 1'b0, 1'b0, 2'd0, 64'h0, 64'h0);
        drive(1, 1'b0, 1'b0, 2'd0, 64'h0, 64'h0);
        repeat (3) @(negedge clk);
        mem_load = 1'b0;
        test_reset();
        test_store64();
        test_load64();
        test_byte();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_sram_bridge.md
# dmem_sram_bridge

Responder end of the pipeline's data-memory strobe protocol: accepts `dmem_rstrobe`/`dmem_wstrobe` accesses of 8/16/32/64 bits and serves them from an external 16-bit asynchronous SRAM. Each access is split into little-endian halfword beats with programmable wait states. The block answers with a single-cycle `dmem_cycle_complete`. It replaces the single-cycle on-chip dmem model when the core runs from board SRAM.

## Interface
- `ADDR_W`, 18, SRAM halfword address width.
- `WAIT_STATES`, 1, extra cycles per beat (0..15).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `dmem_addr`  in  64  byte address of access.
- `dmem_dout`  in  64  write data from pipeline, right-aligned.
- `dmem_write_width`  in  2  access size: 0=64, 1=32, 2=16, 3=8 bits (loads and stores).
- `dmem_rstrobe`  in  1  one-cycle load request.
- `dmem_wstrobe`  in  1  one-cycle store request.
- `dmem_din`  out  64  load data, right-aligned, zero-extended.
- `dmem_cycle_complete`  out  1  one-cycle completion pulse.
- `dmem_err`  out  1  misalignment flag, valid with completion.
- `sram_addr`  out  ADDR_W  halfword address.
- `sram_wdata`  out  16  write data.
- `sram_rdata`  in  16  read data.
- `sram_ce`, `sram_oe`, `sram_we`  out  1 each  active-high strobes (board inverts).
- `sram_be`  out  2  byte enables, bit0 = low byte.

## Operation
- States: IDLE, BEAT, DONE.
- IDLE: a strobe latches addr, width, write data and direction. Beats = 4/2/1/1 for width 0/1/2/3. Base halfword = `dmem_addr[ADDR_W:1]` with the low bits cleared to natural alignment. Go to BEAT.
- Both strobes high in the same cycle: treated as a store.
- Strobes while not IDLE: ignored (protocol violation). No queueing.
- BEAT k drives `sram_addr` = base+k and `sram_ce`=1 for WAIT_STATES+1 cycles.
  - Reads: `sram_oe`=1 for the whole beat. `sram_rdata` is captured on the last cycle into `dmem_din[16k+15:16k]`.
  - Writes: `sram_wdata` = `dmem_dout[16k+15:16k]`. `sram_we`=1 on every beat cycle except the last; if WAIT_STATES=0, `sram_we`=1 for the whole beat.
  - `sram_be`=2'b11, except 8-bit accesses: `dmem_addr[0]` selects the lane. For an 8-bit write, the byte is replicated on both lanes. For an 8-bit read, the selected byte goes to `dmem_din[7:0]`.
- Unused upper `dmem_din` bits are cleared at load start.
- After the last beat: DONE pulses `dmem_cycle_complete` for exactly one cycle, then returns to IDLE.
- `dmem_din` holds until the next load starts.
- Stores leave `dmem_din` untouched.
- `dmem_addr` bits above ADDR_W are ignored (wrap-around).
- Reset, including mid-access: state IDLE, beat and wait counters 0, all outputs 0. No completion is issued for the aborted access.

## Timing
- Strobe sampled at edge 0. Beat k occupies cycles 1+k(W+1) through (k+1)(W+1), where W = WAIT_STATES.
- `dmem_cycle_complete` is high in cycle 1+beats*(W+1).
  - 64-bit, W=1: cycle 9.
  - 8-bit, W=0: cycle 2.
- `dmem_din` is valid in the completion cycle.
- The next strobe is accepted in the cycle after completion.
- SRAM address and data are stable for the whole beat. Beats are back-to-back with no idle gap.

## Configuration
- `RAISIN64_DMEM_ALIGN_CHECK_EN` defined:
  - An access with `dmem_addr` not aligned to its size performs no SRAM cycle.
  - DONE follows IDLE directly: completion and `dmem_err`=1 in cycle 1. `dmem_din` is unchanged.
- Undefined: low address bits are silently truncated to alignment, and `dmem_err` is tied 0.

## Structure
- Package `dmem_bridge_pkg`:
  - width encodings `DW_64`/`DW_32`/`DW_16`/`DW_8`
  - state enum
  - function `beats_for_width`
  - function `is_misaligned(addr, width)`
- No sub-module. One state register plus 2-bit beat counter and 4-bit wait counter.

## Test plan
- 64-bit store, addr 0x10, data 0x1122334455667788, W=1:
  - halfword addrs 8,9,10,11 get 0x7788,0x5566,0x3344,0x1122.
  - completion in cycle 9.
- Load back the same 64-bit value with W=0 -> `dmem_din`=0x1122334455667788, completion in cycle 5.
- 8-bit store 0xAB at addr 0x13 -> `sram_addr`=9, `sram_be`=2'b10, `sram_wdata`=0xABAB.
  - 8-bit load of 0x13 -> `dmem_din`=0x00000000000000AB.
- 32-bit load at addr 0x6 with macro defined -> no `sram_ce`, completion and `dmem_err`=1 in cycle 1.
  - Without the macro -> beats at halfwords 2,3.
- Assert `rst` in cycle 3 of a 64-bit load -> all outputs 0 next cycle, no completion. A new 16-bit load after reset completes normally.
- Simultaneous `dmem_rstrobe` and `dmem_wstrobe` with 16-bit width -> store performed, one completion pulse. A second strobe while busy is ignored.
